// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix sequencer: mode encodings and the
// progressive-fill pixel rule.
package led_matrix_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL   = 2'b00,
        MODE_FWD      = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    // Frame f lights pixels 0..f; frame == pixels is the blank frame.
    function automatic logic pixel_lit(input int unsigned frame,
                                       input int unsigned index,
                                       input int unsigned pixels);
        return (frame < pixels) && (index <= frame);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser and debounce counter for an active-low push-button,
// with a one-cycle pulse on each accepted press.
module button_debounce #(
    parameter int unsigned DEBOUNCE = 65536
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic rise_o
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips on the DEBOUNCE-th consecutive sample that differs from it.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ~btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/led_matrix_sequencer.sv
// Row-multiplexed ROWS x COLS LED matrix driver with a progressive-fill
// animation stepped manually, forward or ping-pong, changing only at scan ends.
module led_matrix_sequencer
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned SCAN_DIV  = 2500,
    parameter int unsigned BLANK     = 2,
    parameter int unsigned FRAME_DIV = 50,
    parameter int unsigned DEBOUNCE  = 65536,
    localparam int unsigned PIXELS   = ROWS * COLS,
    localparam int unsigned FW       = $clog2(PIXELS + 1)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            button_in,
    input  logic [1:0]      mode_in,
    output logic [ROWS-1:0] row_out,
    output logic [COLS-1:0] col_out,
    output logic [FW-1:0]   frame_out,
    output logic            frame_start_out
);

    localparam int unsigned SW  = $clog2(SCAN_DIV);
    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned FDW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [SW-1:0]  SlotMax  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]  BlankEnd = SW'(BLANK);
    localparam logic [RW-1:0]  RowMax   = RW'(ROWS - 1);
    localparam logic [FDW-1:0] ScanMax  = FDW'(FRAME_DIV - 1);
    localparam logic [FW-1:0]  LastFrm  = FW'(PIXELS);

    logic [SW-1:0]   slot_q, slot_d;
    logic [RW-1:0]   row_q, row_d;
    logic [FDW-1:0]  scan_q, scan_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            dir_up_q, dir_up_d;
    logic            pending_q, pending_d;
    mode_e           mode_q, mode_d;
    logic [ROWS-1:0] row_out_q, row_out_d;
    logic [COLS-1:0] col_out_q, col_out_d;
    logic [FW-1:0]   frame_out_q;
    logic            frame_start_q, frame_start_d;

    logic            press;
    logic            slot_wrap, boundary, changed, tick, lit;
    logic [FDW-1:0]  scan_eff;
    logic [FW-1:0]   frame_fwd;
    mode_e           mode_new;

    button_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_button_debounce (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .btn_n_i (button_in),
        .rise_o  (press)
    );

    always_comb begin
        slot_wrap = (slot_q == SlotMax);
        boundary  = slot_wrap && (row_q == RowMax);
        slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
        row_d     = row_q;
        if (slot_wrap) begin
            row_d = (row_q == RowMax) ? '0 : row_q + 1'b1;
        end

        mode_new  = mode_e'(mode_in);
        changed   = boundary && (mode_new != mode_q);
        scan_eff  = changed ? '0 : scan_q;
        tick      = (scan_eff == ScanMax);
        frame_fwd = (frame_q == LastFrm) ? '0 : frame_q + 1'b1;

        mode_d    = boundary ? mode_new : mode_q;
        scan_d    = scan_q;
        frame_d   = frame_q;
        dir_up_d  = dir_up_q;
        pending_d = pending_q;

        if (boundary) begin
            // Every boundary consumes or discards the pending step.
            pending_d = 1'b0;
            scan_d    = scan_eff;
            unique case (mode_new)
                MODE_MANUAL: begin
                    if (!changed && pending_q) frame_d = frame_fwd;
                end
                MODE_FWD: begin
                    scan_d = tick ? '0 : scan_eff + 1'b1;
                    if (tick) frame_d = frame_fwd;
                end
                MODE_PINGPONG: begin
                    scan_d = tick ? '0 : scan_eff + 1'b1;
                    if (tick) begin
                        if (dir_up_q) begin
                            if (frame_q == LastFrm) begin
                                dir_up_d = 1'b0;
                                frame_d  = LastFrm - 1'b1;
                            end else begin
                                frame_d  = frame_q + 1'b1;
                            end
                        end else if (frame_q == '0) begin
                            dir_up_d = 1'b1;
                            frame_d  = FW'(1);
                        end else begin
                            frame_d  = frame_q - 1'b1;
                        end
                    end
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end

        // A press on a boundary cycle survives to the following boundary.
        if (press && (mode_d == MODE_MANUAL)) pending_d = 1'b1;

        lit = (slot_q >= BlankEnd);
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_out_d[r] = lit && (row_q == RW'(r));
        end
        for (int unsigned c = 0; c < COLS; c++) begin
            col_out_d[c] = lit && pixel_lit(32'(frame_q), 32'(row_q) * COLS + c, PIXELS);
        end
        frame_start_d = (slot_q == '0) && (row_q == '0);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slot_q        <= '0;
            row_q         <= '0;
            scan_q        <= '0;
            frame_q       <= '0;
            dir_up_q      <= 1'b1;
            pending_q     <= 1'b0;
            mode_q        <= MODE_MANUAL;
            row_out_q     <= '0;
            col_out_q     <= '0;
            frame_out_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            row_q         <= row_d;
            scan_q        <= scan_d;
            frame_q       <= frame_d;
            dir_up_q      <= dir_up_d;
            pending_q     <= pending_d;
            mode_q        <= mode_d;
            row_out_q     <= row_out_d;
            col_out_q     <= col_out_d;
            frame_out_q   <= frame_q;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_out         = row_out_q;
    assign col_out         = col_out_q;
    assign frame_out       = frame_out_q;
    assign frame_start_out = frame_start_q;

endmodule
